// File: rtl/raizing_colmix.sv
// Two-stage layer mixer: TXT over priority-sorted SPR/FG/BG, with a backdrop fallback.
// Optional macro RAIZING_COLMIX_LAYER_MASK_EN adds a per-layer LAYER_MASK input.
module raizing_colmix #(
  parameter bit BD_SYNC = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PIXEL_CEN,
  input  logic        LHBL,
  input  logic        LVBL,
  input  logic [10:0] TXT_PIX,
  input  logic [14:0] SPR_PIX,
  input  logic [14:0] FG_PIX,
  input  logic [14:0] BG_PIX,
  input  logic        BD_WE,
  input  logic [10:0] BD_DATA,
`ifdef RAIZING_COLMIX_LAYER_MASK_EN
  input  logic [3:0]  LAYER_MASK,
`endif
  output logic [10:0] PIXEL,
  output logic        ACTIVE,
  output logic        LHBL_MIX,
  output logic        LVBL_MIX,
  output logic        BD_PEND
);

  typedef enum logic {S_IDLE, S_PEND} bd_state_t;

  logic [3:0]  w_mask;
  logic [10:0] r_s1_txt;
  logic [14:0] r_s1_spr, r_s1_fg, r_s1_bg;
  logic        r_s1_lhbl, r_s1_lvbl;
  logic [3:0]  r_s1_op;   // opaque flags {txt, spr, fg, bg}

  bd_state_t   r_bd_state, w_bd_state_nxt;
  logic [10:0] r_bd_shadow, w_bd_shadow_nxt;
  logic [10:0] r_bd_active, w_bd_active_nxt;
  logic        w_vb_start;

  logic [10:0] w_mix;
  logic [3:0]  w_best_pri;
  logic        w_have;

`ifdef RAIZING_COLMIX_LAYER_MASK_EN
  assign w_mask = LAYER_MASK;
`else
  assign w_mask = 4'b0000;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s1_txt  <= '0;
      r_s1_spr  <= '0;
      r_s1_fg   <= '0;
      r_s1_bg   <= '0;
      r_s1_lhbl <= 1'b0;
      r_s1_lvbl <= 1'b0;
      r_s1_op   <= 4'b0000;
    end else if (PIXEL_CEN) begin
      r_s1_txt  <= TXT_PIX;
      r_s1_spr  <= SPR_PIX;
      r_s1_fg   <= FG_PIX;
      r_s1_bg   <= BG_PIX;
      r_s1_lhbl <= LHBL;
      r_s1_lvbl <= LVBL;
      r_s1_op   <= {(TXT_PIX[3:0] != 4'd0) && !w_mask[3],
                    (SPR_PIX[3:0] != 4'd0) && !w_mask[2],
                    (FG_PIX[3:0]  != 4'd0) && !w_mask[1],
                    (BG_PIX[3:0]  != 4'd0) && !w_mask[0]};
    end
  end

  // Later layers replace on >=, so on equal priority SPR beats FG beats BG.
  always_comb begin
    w_mix      = r_bd_active;
    w_best_pri = 4'd0;
    w_have     = 1'b0;
    if (r_s1_op[0]) begin
      w_mix      = r_s1_bg[10:0];
      w_best_pri = r_s1_bg[14:11];
      w_have     = 1'b1;
    end
    if (r_s1_op[1] && (!w_have || r_s1_fg[14:11] >= w_best_pri)) begin
      w_mix      = r_s1_fg[10:0];
      w_best_pri = r_s1_fg[14:11];
      w_have     = 1'b1;
    end
    if (r_s1_op[2] && (!w_have || r_s1_spr[14:11] >= w_best_pri)) begin
      w_mix      = r_s1_spr[10:0];
      w_best_pri = r_s1_spr[14:11];
      w_have     = 1'b1;
    end
    if (r_s1_op[3]) begin
      w_mix = r_s1_txt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      PIXEL    <= '0;
      ACTIVE   <= 1'b0;
      LHBL_MIX <= 1'b0;
      LVBL_MIX <= 1'b0;
    end else if (PIXEL_CEN) begin
      LHBL_MIX <= r_s1_lhbl;
      LVBL_MIX <= r_s1_lvbl;
      if (r_s1_lhbl && r_s1_lvbl) begin
        PIXEL  <= w_mix;
        ACTIVE <= 1'b1;
      end else begin
        PIXEL  <= '0;
        ACTIVE <= 1'b0;
      end
    end
  end

  // Vertical-blank start: stage-1 LVBL is about to go from 1 to 0.
  assign w_vb_start = PIXEL_CEN && r_s1_lvbl && !LVBL;

  always_comb begin
    w_bd_state_nxt  = r_bd_state;
    w_bd_shadow_nxt = r_bd_shadow;
    w_bd_active_nxt = r_bd_active;
    if (!BD_SYNC) begin
      w_bd_state_nxt = S_IDLE;
      if (BD_WE) w_bd_active_nxt = BD_DATA;
    end else if (BD_WE && w_vb_start) begin
      w_bd_active_nxt = BD_DATA;
      w_bd_state_nxt  = S_IDLE;
    end else if (BD_WE) begin
      w_bd_shadow_nxt = BD_DATA;
      w_bd_state_nxt  = S_PEND;
    end else if (r_bd_state == S_PEND && w_vb_start) begin
      w_bd_active_nxt = r_bd_shadow;
      w_bd_state_nxt  = S_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_bd_state  <= S_IDLE;
      r_bd_shadow <= '0;
      r_bd_active <= '0;
    end else begin
      r_bd_state  <= w_bd_state_nxt;
      r_bd_shadow <= w_bd_shadow_nxt;
      r_bd_active <= w_bd_active_nxt;
    end
  end

  assign BD_PEND = (r_bd_state == S_PEND);

endmodule

// File: tb/tb_raizing_colmix.sv
// Bench for raizing_colmix: directed scenarios plus randomized frames against a pixel-level model.
// Drives one instance with deferred backdrop writes and one with immediate writes.
module tb_raizing_colmix;

  logic        clk;
  logic        rst;
  logic        cen;
  logic        lhbl, lvbl;
  logic [10:0] txt;
  logic [14:0] spr, fg, bg;
  logic        bd_we;
  logic [10:0] bd_data;
  logic [3:0]  mask;

  logic [10:0] pixel, pixel0;
  logic        active, active0, lh_mix, lh0, lv_mix, lv0, pend, pend0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [10:0] txt;
    logic [14:0] spr;
    logic [14:0] fg;
    logic [14:0] bg;
    logic        lhbl;
    logic        lvbl;
    logic [3:0]  msk;
  } pix_t;

  pix_t        m_s1;
  logic [10:0] m_pix0;
  logic        m_act, m_lh, m_lv;
  logic [10:0] bd1_act, bd1_sh, bd0_act;
  logic        bd1_pend;
  logic [10:0] exp_q[$];

  raizing_colmix #(.BD_SYNC(1'b1)) dut (
    .CLK(clk), .RESET(rst), .PIXEL_CEN(cen), .LHBL(lhbl), .LVBL(lvbl),
    .TXT_PIX(txt), .SPR_PIX(spr), .FG_PIX(fg), .BG_PIX(bg),
    .BD_WE(bd_we), .BD_DATA(bd_data),
`ifdef RAIZING_COLMIX_LAYER_MASK_EN
    .LAYER_MASK(mask),
`endif
    .PIXEL(pixel), .ACTIVE(active), .LHBL_MIX(lh_mix), .LVBL_MIX(lv_mix), .BD_PEND(pend)
  );

  raizing_colmix #(.BD_SYNC(1'b0)) dut0 (
    .CLK(clk), .RESET(rst), .PIXEL_CEN(cen), .LHBL(lhbl), .LVBL(lvbl),
    .TXT_PIX(txt), .SPR_PIX(spr), .FG_PIX(fg), .BG_PIX(bg),
    .BD_WE(bd_we), .BD_DATA(bd_data),
`ifdef RAIZING_COLMIX_LAYER_MASK_EN
    .LAYER_MASK(mask),
`endif
    .PIXEL(pixel0), .ACTIVE(active0), .LHBL_MIX(lh0), .LVBL_MIX(lv0), .BD_PEND(pend0)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference rule: opaque text wins; else highest-priority opaque layer, earliest in SPR,FG,BG on ties.
  function automatic logic [10:0] mix_ref(input pix_t p, input logic [10:0] bd);
    logic [14:0] lay [3];
    int          best;
    logic [3:0]  bp;
    lay[0] = p.spr;
    lay[1] = p.fg;
    lay[2] = p.bg;
    best   = -1;
    bp     = 4'd0;
    if (p.txt[3:0] != 4'd0 && !p.msk[3]) return p.txt;
    for (int i = 0; i < 3; i++) begin
      if (lay[i][3:0] != 4'd0 && !p.msk[2-i] && (best < 0 || lay[i][14:11] > bp)) begin
        best = i;
        bp   = lay[i][14:11];
      end
    end
    if (best < 0) return bd;
    return lay[best][10:0];
  endfunction

  task automatic model_step();
    pix_t cur;
    logic vb;
    cur.txt = txt; cur.spr = spr; cur.fg = fg; cur.bg = bg;
    cur.lhbl = lhbl; cur.lvbl = lvbl; cur.msk = mask;
    if (rst) begin
      m_s1 = '0; m_pix0 = '0; m_act = 1'b0; m_lh = 1'b0; m_lv = 1'b0;
      bd1_act = '0; bd1_sh = '0; bd1_pend = 1'b0; bd0_act = '0;
      exp_q.delete();
    end else begin
      vb = cen && m_s1.lvbl && !lvbl;
      if (cen) begin
        if (m_s1.lhbl && m_s1.lvbl) begin
          exp_q.push_back(mix_ref(m_s1, bd1_act));
          m_pix0 = mix_ref(m_s1, bd0_act);
          m_act  = 1'b1;
        end else begin
          exp_q.push_back(11'd0);
          m_pix0 = '0;
          m_act  = 1'b0;
        end
        if (exp_q.size() > 8) void'(exp_q.pop_front());
        m_lh = m_s1.lhbl;
        m_lv = m_s1.lvbl;
        m_s1 = cur;
      end
      if (bd_we && vb) begin
        bd1_act = bd_data; bd1_pend = 1'b0;
      end else if (bd_we) begin
        bd1_sh = bd_data; bd1_pend = 1'b1;
      end else if (bd1_pend && vb) begin
        bd1_act = bd1_sh; bd1_pend = 1'b0;
      end
      if (bd_we) bd0_act = bd_data;
    end
  endtask

  task automatic compare_all();
    logic [10:0] ep;
    ep = (exp_q.size() > 0) ? exp_q[$] : 11'd0;
    check("pixel",    16'(pixel),  16'(ep));
    check("active",   16'(active), 16'(m_act));
    check("lhbl_mix", 16'(lh_mix), 16'(m_lh));
    check("lvbl_mix", 16'(lv_mix), 16'(m_lv));
    check("bd_pend",  16'(pend),   16'(bd1_pend));
    check("pixel_nosync",   16'(pixel0),  16'(m_pix0));
    check("active_nosync",  16'(active0), 16'(m_act));
    check("bd_pend_nosync", 16'(pend0),   16'd0);
  endtask

  // Driver: inputs are already set; advance one clock and compare #1 after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_layers(input logic [10:0] t, input logic [14:0] s,
                            input logic [14:0] f, input logic [14:0] b);
    txt = t; spr = s; fg = f; bg = b;
  endtask

  function automatic logic [14:0] rnd_layer();
    logic [14:0] v;
    v[14:11] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    v[10:0]  = 11'($urandom_range(0, 2047));
    if ($urandom_range(0, 2) == 0) v[3:0] = 4'd0;
    return v;
  endfunction

  initial begin
    int h, v;
    logic [10:0] t;
    rst = 1'b1; cen = 1'b1; lhbl = 1'b0; lvbl = 1'b0;
    set_layers(11'h0, 15'h0, 15'h0, 15'h0);
    bd_we = 1'b0; bd_data = '0; mask = 4'b0000;
    repeat (3) tick();
    check("reset_pixel",  16'(pixel),  16'h000);
    check("reset_active", 16'(active), 16'h0);
    check("reset_lvbl",   16'(lv_mix), 16'h0);
    check("reset_pend",   16'(pend),   16'h0);
    rst = 1'b0;

    // Priority: BG wins over an SPR/FG tie at lower priority.
    lhbl = 1'b1; lvbl = 1'b1;
    set_layers(11'h000, {4'd5, 11'h123}, {4'd5, 11'h456}, {4'd9, 11'h0F1});
    repeat (2) tick();
    check("prio_bg",        16'(pixel),  16'h0F1);
    check("prio_bg_active", 16'(active), 16'h1);
    set_layers(11'h201, {4'd5, 11'h123}, {4'd5, 11'h456}, {4'd9, 11'h0F1});
    repeat (2) tick();
    check("txt_wins", 16'(pixel), 16'h201);
    set_layers(11'h000, {4'd5, 11'h123}, {4'd5, 11'h456}, {4'd9, 11'h0F0});
    repeat (2) tick();
    check("tie_spr", 16'(pixel), 16'h123);

    // Backdrop write coincident with vertical-blank start is applied at once.
    set_layers(11'h000, 15'h0, 15'h0, 15'h0);
    bd_we = 1'b1; bd_data = 11'h7F0; lvbl = 1'b0;
    tick();
    bd_we = 1'b0; lvbl = 1'b1;
    check("coincident_pend", 16'(pend), 16'h0);
    repeat (2) tick();
    check("backdrop", 16'(pixel), 16'h7F0);
    lhbl = 1'b0;
    repeat (2) tick();
    check("hblank_pixel",  16'(pixel),  16'h000);
    check("hblank_active", 16'(active), 16'h0);
    lhbl = 1'b1;

    // Deferred backdrop writes.
    bd_we = 1'b1; bd_data = 11'h010; tick();
    bd_data = 11'h020; tick();
    bd_we = 1'b0;
    check("pend_set", 16'(pend), 16'h1);
    repeat (2) tick();
    check("bd_deferred",  16'(pixel),  16'h7F0);
    check("bd_immediate", 16'(pixel0), 16'h020);
    lvbl = 1'b0; tick();
    check("pend_clr", 16'(pend), 16'h0);
    lvbl = 1'b1;
    repeat (2) tick();
    check("bd_applied", 16'(pixel), 16'h020);

    // Outputs hold while the pixel enable is low.
    cen = 1'b0;
    set_layers(11'h2A5, 15'h0, 15'h0, 15'h0);
    lhbl = 1'b0;
    repeat (3) tick();
    check("hold_pixel", 16'(pixel), 16'h020);
    cen = 1'b1; lhbl = 1'b1;
    set_layers(11'h000, 15'h0, 15'h0, 15'h0);

    // Reset discards a pending write.
    bd_we = 1'b1; bd_data = 11'h030; tick();
    bd_we = 1'b0;
    check("pend_before_rst", 16'(pend), 16'h1);
    rst = 1'b1; tick();
    check("rst_pend",  16'(pend),  16'h0);
    check("rst_pixel", 16'(pixel), 16'h000);
    rst = 1'b0;
    tick();
    lvbl = 1'b0; tick();
    lvbl = 1'b1; repeat (2) tick();
    check("rst_backdrop", 16'(pixel), 16'h000);

`ifdef RAIZING_COLMIX_LAYER_MASK_EN
    mask = 4'b0100;
    set_layers(11'h000, {4'hF, 11'h123}, {4'h1, 11'h456}, 15'h0);
    repeat (2) tick();
    check("mask_spr", 16'(pixel), 16'h456);
`endif

    // Randomized frames.
    h = 0; v = 0;
    for (int n = 0; n < 4000; n++) begin
      cen  = ($urandom_range(0, 3) != 0);
      lhbl = (h < 9);
      lvbl = (v < 6);
      t    = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 1) == 0) t[3:0] = 4'd0;
      set_layers(t, rnd_layer(), rnd_layer(), rnd_layer());
      bd_we   = ($urandom_range(0, 15) == 0);
      bd_data = 11'($urandom_range(0, 2047));
      rst     = ($urandom_range(0, 399) == 0);
`ifdef RAIZING_COLMIX_LAYER_MASK_EN
      mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
`endif
      tick();
      if (cen) begin
        h = (h == 11) ? 0 : h + 1;
        if (h == 0) v = (v == 7) ? 0 : v + 1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/raizing_colmix.md
RAIZING_COLMIX -- requirements
Module: raizing_colmix

Interface
REQ-001 Parameter BD_SYNC, default 1; 1 = backdrop writes deferred to vertical-blank start, 0 = backdrop writes applied on the next clock.
REQ-002 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 PIXEL_CEN  in  1  pixel clock enable; the pipeline advances only when it is high.
REQ-005 LHBL, LVBL  in  1 each  active-low blanking, aligned with the layer inputs.
REQ-006 TXT_PIX  in  11  text-layer palette index; transparent when bits [3:0] are 0.
REQ-007 SPR_PIX, FG_PIX, BG_PIX  in  15 each  {prio[3:0], index[10:0]}; transparent when index[3:0] is 0.
REQ-008 BD_WE  in  1  one-cycle backdrop write strobe.
REQ-009 BD_DATA  in  11  backdrop palette index.
REQ-010 PIXEL  out  11  mixed palette index, feeding the palette stage.
REQ-011 ACTIVE  out  1  high when the PIXEL output is in the visible area.
REQ-012 LHBL_MIX, LVBL_MIX  out  1 each  blanking delayed to match PIXEL.
REQ-013 BD_PEND  out  1  high while a backdrop write awaits vertical blank.

Function
REQ-014 The pipeline has 2 stages, each advancing only on PIXEL_CEN; the latency from any input to PIXEL/ACTIVE/LHBL_MIX/LVBL_MIX is exactly 2 PIXEL_CEN pulses.
REQ-015 Stage 1 registers all layer inputs and blanking, and computes one opaque flag per layer.
REQ-016 Stage 2 selects the output:
- an opaque TXT wins unconditionally;
- otherwise the opaque layer among SPR/FG/BG with the highest prio wins;
- prio ties resolve SPR > FG > BG;
- if no layer is opaque, the output is the active backdrop register.
REQ-017 Priority comparison is unsigned over 4 bits; prio 0 is valid and still beats a transparent layer.
REQ-018 When a stage-2 pixel has LHBL=0 or LVBL=0, PIXEL is 0 and ACTIVE is 0; otherwise ACTIVE is 1.
REQ-019 Outputs hold their value on cycles where PIXEL_CEN is low.
REQ-020 Backdrop control with BD_SYNC=1 is a two-state FSM, IDLE and PEND:
- BD_WE in IDLE loads the shadow register and moves to PEND;
- BD_WE in PEND overwrites the shadow register and stays in PEND;
- in PEND, a falling edge of stage-1 LVBL (sampled on PIXEL_CEN) copies shadow to active and returns to IDLE;
- BD_PEND = (state == PEND).
REQ-021 If BD_WE coincides with the LVBL falling edge, the new BD_DATA goes straight to the active register and the state becomes IDLE.
REQ-022 With BD_SYNC=0, BD_WE loads the active register on the next clock, independent of PIXEL_CEN; BD_PEND is held at 0.
REQ-023 A new active backdrop value affects only pixels entering stage 2 after the update.

Reset
REQ-024 While RESET is high:
- PIXEL=0, ACTIVE=0, LHBL_MIX=0, LVBL_MIX=0;
- the pipeline registers are cleared to transparent;
- the active and shadow backdrop registers are 0;
- the FSM is IDLE and BD_PEND=0.
REQ-025 RESET asserted mid-frame or with a write pending discards the pending write.
REQ-026 After RESET deasserts, 2 PIXEL_CEN pulses are needed before the outputs reflect new inputs.

Configuration
REQ-027 Macro RAIZING_COLMIX_LAYER_MASK_EN, when defined, adds an input LAYER_MASK[3:0] with bits {TXT,SPR,FG,BG}:
- a set bit forces that layer transparent in stage 1;
- LAYER_MASK is sampled with the other inputs.
REQ-028 When RAIZING_COLMIX_LAYER_MASK_EN is undefined, the LAYER_MASK port is absent and all layers are always enabled.

Verification
REQ-029 SPR=(prio 5, 0x123), FG=(prio 5, 0x456), BG=(prio 9, 0x0F1), TXT=0x000, visible -> PIXEL=0x0F1, ACTIVE=1, 2 PIXEL_CEN pulses later.
REQ-030 BG=(9, 0x0F1), TXT=0x201 -> PIXEL=0x201. Then SPR and FG at prio 5 with TXT=0 and BG transparent -> PIXEL=0x123 (tie won by SPR).
REQ-031 All layers transparent and backdrop 0x7F0 -> PIXEL=0x7F0. Same stimulus with LHBL=0 -> PIXEL=0, ACTIVE=0.
REQ-032 BD_SYNC=1: write 0x010 mid-line, then 0x020 -> BD_PEND=1 and backdrop output unchanged. At LVBL fall -> active=0x020 and BD_PEND=0. A write coincident with LVBL fall -> applied immediately, BD_PEND stays 0.
REQ-033 Pending write 0x030, then RESET pulse -> BD_PEND=0, backdrop 0, PIXEL=0.
REQ-034 With RAIZING_COLMIX_LAYER_MASK_EN: LAYER_MASK=4'b0100 and SPR=(prio F, 0x123), FG=(prio 1, 0x456) -> PIXEL=0x456.
